// File: rtl/ctl_que_fetch.sv
// Control-queue fetcher: walks a circular queue of 8-byte command entries, polls invalid
// entries and forwards valid ones to the units. Optional macro: CTLQ_SEQ_CHK_EN (sequence check).
module ctl_que_fetch #(
    parameter int unsigned POLL_DLY = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [47:0] ctlQueBase,
    input  logic [15:0] ctlQueWidth,
    output logic        busy,
    output logic        mem_rd_req_vld,
    output logic [47:0] mem_rd_req_addr,
    input  logic        mem_rd_req_rdy,
    input  logic        mem_rd_rsp_vld,
    input  logic [63:0] mem_rd_rsp_data,
    output logic        cmd_vld,
    output logic [63:0] cmd_data,
    input  logic        cmd_rdy
);

    localparam int unsigned ADDR_W = 48;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned IDX_W  = 22;
    localparam int unsigned SEQ_W  = 14;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_POLL
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [IDX_W-1:0]    mask_q, mask_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                busy_q, req_vld_q, cmd_vld_q;

    logic [15:0]         shamt_c;
    logic [IDX_W:0]      mask_full_c;
    logic                entry_ok_c;
    logic                entry_halt_c;

    // Index mask covers 2^(width-3) entries of 8 bytes each.
    assign shamt_c     = ctlQueWidth - 16'd3;
    assign mask_full_c = ((IDX_W+1)'(1) << shamt_c) - (IDX_W+1)'(1);

`ifdef CTLQ_SEQ_CHK_EN
    assign entry_ok_c = mem_rd_rsp_data[63] && (mem_rd_rsp_data[61:48] == seq_q);
`else
    assign entry_ok_c = mem_rd_rsp_data[63];
`endif
    assign entry_halt_c = mem_rd_rsp_data[62];

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = ctlQueBase;
                    mask_d  = mask_full_c[IDX_W-1:0];
                    idx_d   = '0;
                    seq_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_rd_req_rdy) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rd_rsp_vld) begin
                    if (!entry_ok_c) begin
                        cnt_d   = '0;
                        state_d = S_POLL;
                    end else if (entry_halt_c) begin
                        state_d = S_IDLE;
                    end else begin
                        data_d  = mem_rd_rsp_data;
                        state_d = S_OUT;
                    end
                end
            end
            S_POLL: begin
                if (cnt_q == CNT_W'(POLL_DLY - 1)) begin
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                if (cmd_rdy) begin
                    idx_d   = (idx_q + IDX_W'(1)) & mask_q;
                    seq_d   = seq_q + SEQ_W'(1);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        addr_d = base_d + ADDR_W'({idx_d, 3'b000});
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            mask_q    <= '0;
            idx_q     <= '0;
            seq_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            req_vld_q <= 1'b0;
            cmd_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            busy_q    <= (state_d != S_IDLE);
            req_vld_q <= (state_d == S_REQ);
            cmd_vld_q <= (state_d == S_OUT);
        end
    end

    assign busy            = busy_q;
    assign mem_rd_req_vld  = req_vld_q;
    assign mem_rd_req_addr = addr_q;
    assign cmd_vld         = cmd_vld_q;
    assign cmd_data        = data_q;

endmodule

// File: tb/tb_ctl_que_fetch.sv
// Scoreboard bench for ctl_que_fetch: directed queue images, a memory responder,
// and a monitor that checks read addresses and commands against expected queues.
module tb_ctl_que_fetch;

    localparam int unsigned POLL_DLY = 4;
`ifdef CTLQ_SEQ_CHK_EN
    localparam bit SEQ_CHK = 1'b1;
`else
    localparam bit SEQ_CHK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [47:0] ctlQueBase;
    logic [15:0] ctlQueWidth;
    logic        busy;
    logic        mem_rd_req_vld;
    logic [47:0] mem_rd_req_addr;
    logic        mem_rd_req_rdy;
    logic        mem_rd_rsp_vld;
    logic [63:0] mem_rd_rsp_data;
    logic        cmd_vld;
    logic [63:0] cmd_data;
    logic        cmd_rdy;

    ctl_que_fetch #(.POLL_DLY(POLL_DLY)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .ctlQueBase     (ctlQueBase),
        .ctlQueWidth    (ctlQueWidth),
        .busy           (busy),
        .mem_rd_req_vld (mem_rd_req_vld),
        .mem_rd_req_addr(mem_rd_req_addr),
        .mem_rd_req_rdy (mem_rd_req_rdy),
        .mem_rd_rsp_vld (mem_rd_rsp_vld),
        .mem_rd_rsp_data(mem_rd_rsp_data),
        .cmd_vld        (cmd_vld),
        .cmd_data       (cmd_data),
        .cmd_rdy        (cmd_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int read_cnt = 0;
    int cmd_cnt = 0;
    int last_rsp_cyc = -1000;
    logic [47:0] prev_addr = '1;

    logic [47:0] exp_rd[$];
    logic [63:0] exp_cmd[$];

    // Memory image; "pre" data is returned for the first pre_cnt reads of an address.
    logic [63:0] mem[logic [47:0]];
    logic [63:0] pre[logic [47:0]];
    int          pre_cnt[logic [47:0]];
    int          rd_cnt[logic [47:0]];
    bit          rsp_en = 1'b1;
    bit          inject = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ent(input logic v, input logic h, input int seq,
                                        input logic [47:0] pay);
        return {v, h, 14'(seq), pay};
    endfunction

    function automatic logic [63:0] rd_mem(input logic [47:0] a);
        int n;
        n = rd_cnt.exists(a) ? rd_cnt[a] : 0;
        rd_cnt[a] = n + 1;
        if (pre_cnt.exists(a) && n < pre_cnt[a]) return pre[a];
        if (mem.exists(a)) return mem[a];
        return 64'd0;
    endfunction

    task automatic clear_mem();
        mem.delete();
        pre.delete();
        pre_cnt.delete();
        rd_cnt.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [47:0] base, input logic [15:0] width);
        tick();
        ctlQueBase  = base;
        ctlQueWidth = width;
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (busy && i < 3000) begin
            tick();
            i++;
        end
        chk({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    // Zero-latency responder: answers in the cycle after each accepted request.
    initial begin
        logic        hs;
        logic [47:0] a;
        mem_rd_rsp_vld  = 1'b0;
        mem_rd_rsp_data = '0;
        forever begin
            @(negedge clk);
            hs = mem_rd_req_vld && mem_rd_req_rdy && !reset;
            a  = mem_rd_req_addr;
            @(posedge clk);
            #1;
            mem_rd_rsp_vld = 1'b0;
            if (inject) begin
                mem_rd_rsp_vld  = 1'b1;
                mem_rd_rsp_data = ent(1'b1, 1'b0, 0, 48'h55);
                inject          = 1'b0;
            end else if (hs && rsp_en) begin
                mem_rd_rsp_vld  = 1'b1;
                mem_rd_rsp_data = rd_mem(a);
            end
        end
    end

    // Monitor: pops expected reads/commands on each handshake.
    always @(negedge clk) begin
        cyc++;
        if (!reset && mem_rd_req_vld && mem_rd_req_rdy) begin
            read_cnt++;
            if (exp_rd.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got read 0x%0h, expected no read", mem_rd_req_addr);
            end else begin
                chk("rd_addr", 64'(mem_rd_req_addr), 64'(exp_rd.pop_front()));
            end
            if (mem_rd_req_addr == prev_addr) begin
                chk("poll_gap_ok", 64'((cyc - last_rsp_cyc) >= int'(POLL_DLY)), 64'd1);
            end
            prev_addr = mem_rd_req_addr;
        end
        if (mem_rd_rsp_vld) last_rsp_cyc = cyc;
        if (!reset && cmd_vld && cmd_rdy) begin
            cmd_cnt++;
            if (exp_cmd.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL cmd_unexpected: got cmd 0x%0h, expected no cmd", cmd_data);
            end else begin
                chk("cmd_data", cmd_data, exp_cmd.pop_front());
            end
        end
    end

    initial begin
        int rc;
        int cc;
        int i;
        reset          = 1'b1;
        start          = 1'b0;
        ctlQueBase     = '0;
        ctlQueWidth    = 16'd9;
        mem_rd_req_rdy = 1'b1;
        cmd_rdy        = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_vld", 64'(mem_rd_req_vld), 64'd0);
        chk("rst_cmd_vld", 64'(cmd_vld), 64'd0);
        reset = 1'b0;
        tick();

        // Three commands then a halt.
        clear_mem();
        for (int k = 0; k < 3; k++) begin
            mem[48'h1000 + 48'(8 * k)] = ent(1'b1, 1'b0, k, 48'hA + 48'(k));
            exp_rd.push_back(48'h1000 + 48'(8 * k));
            exp_cmd.push_back(ent(1'b1, 1'b0, k, 48'hA + 48'(k)));
        end
        mem[48'h1018] = ent(1'b1, 1'b1, 3, 48'h0);
        exp_rd.push_back(48'h1018);
        do_start(48'h1000, 16'd9);
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        wait_idle("t1");
        tick();
        chk("t1_cmd_vld", 64'(cmd_vld), 64'd0);
        chk("t1_req_vld", 64'(mem_rd_req_vld), 64'd0);
        chk("t1_rd_left", 64'(exp_rd.size()), 64'd0);
        chk("t1_cmd_left", 64'(exp_cmd.size()), 64'd0);

        // Full lap of 64 entries, halt found at index 0 on the second lap.
        clear_mem();
        cc = cmd_cnt;
        for (int k = 0; k < 64; k++) begin
            mem[48'h20000 + 48'(8 * k)] = ent(1'b1, 1'b0, k, 48'h100 + 48'(k));
            exp_rd.push_back(48'h20000 + 48'(8 * k));
            exp_cmd.push_back(ent(1'b1, 1'b0, k, 48'h100 + 48'(k)));
        end
        pre[48'h20000]     = mem[48'h20000];
        pre_cnt[48'h20000] = 1;
        mem[48'h20000]     = ent(1'b1, 1'b1, 64, 48'h0);
        exp_rd.push_back(48'h20000);
        do_start(48'h20000, 16'd9);
        wait_idle("t2");
        chk("t2_cmd_count", 64'(cmd_cnt - cc), 64'd64);
        chk("t2_rd_left", 64'(exp_rd.size()), 64'd0);

        // Entry 0 invalid for two reads.
        clear_mem();
        pre[48'h3000]     = ent(1'b0, 1'b0, 0, 48'h33);
        pre_cnt[48'h3000] = 2;
        mem[48'h3000]     = ent(1'b1, 1'b0, 0, 48'h33);
        mem[48'h3008]     = ent(1'b1, 1'b1, 1, 48'h0);
        repeat (3) exp_rd.push_back(48'h3000);
        exp_rd.push_back(48'h3008);
        exp_cmd.push_back(ent(1'b1, 1'b0, 0, 48'h33));
        do_start(48'h3000, 16'd10);
        wait_idle("t3");
        chk("t3_rd_left", 64'(exp_rd.size()), 64'd0);
        chk("t3_cmd_left", 64'(exp_cmd.size()), 64'd0);

        // Backpressure on cmd_rdy, plus a start pulse mid-run.
        clear_mem();
        mem[48'h4000] = ent(1'b1, 1'b0, 0, 48'h40);
        mem[48'h4008] = ent(1'b1, 1'b0, 1, 48'h41);
        mem[48'h4010] = ent(1'b1, 1'b1, 2, 48'h0);
        exp_rd.push_back(48'h4000);
        exp_rd.push_back(48'h4008);
        exp_rd.push_back(48'h4010);
        exp_cmd.push_back(ent(1'b1, 1'b0, 0, 48'h40));
        exp_cmd.push_back(ent(1'b1, 1'b0, 1, 48'h41));
        cmd_rdy = 1'b0;
        do_start(48'h4000, 16'd9);
        i = 0;
        while (!cmd_vld && i < 100) begin
            tick();
            i++;
        end
        chk("t4_cmd_vld_seen", 64'(cmd_vld), 64'd1);
        rc = read_cnt;
        ctlQueBase = 48'h9000;
        for (int k = 0; k < 10; k++) begin
            chk("t4_stall_vld", 64'(cmd_vld), 64'd1);
            chk("t4_stall_data", cmd_data, ent(1'b1, 1'b0, 0, 48'h40));
            start = (k == 3);
            tick();
        end
        start = 1'b0;
        chk("t4_no_read_in_stall", 64'(read_cnt - rc), 64'd0);
        cmd_rdy = 1'b1;
        wait_idle("t4");
        chk("t4_rd_left", 64'(exp_rd.size()), 64'd0);

        // Reset while waiting for a response; late response must be ignored.
        clear_mem();
        rsp_en = 1'b0;
        exp_rd.push_back(48'h5000);
        rc = read_cnt;
        do_start(48'h5000, 16'd9);
        i = 0;
        while (read_cnt == rc && i < 100) begin
            tick();
            i++;
        end
        chk("t5_read_issued", 64'(read_cnt - rc), 64'd1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("t5_rst_over_start_busy", 64'(busy), 64'd0);
        inject = 1'b1;
        repeat (4) tick();
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_cmd_vld", 64'(cmd_vld), 64'd0);
        chk("t5_req_vld", 64'(mem_rd_req_vld), 64'd0);
        rsp_en = 1'b1;
        mem[48'h5000] = ent(1'b1, 1'b1, 0, 48'h0);
        exp_rd.push_back(48'h5000);
        do_start(48'h5000, 16'd9);
        wait_idle("t5");
        chk("t5_rd_left", 64'(exp_rd.size()), 64'd0);

        // Stale sequence number on entry 1.
        clear_mem();
        mem[48'h6000]     = ent(1'b1, 1'b0, 0, 48'h60);
        pre[48'h6008]     = ent(1'b1, 1'b0, 5, 48'h61);
        pre_cnt[48'h6008] = 2;
        mem[48'h6008]     = ent(1'b1, 1'b0, 1, 48'h61);
        mem[48'h6010]     = ent(1'b1, 1'b1, 2, 48'h0);
        exp_rd.push_back(48'h6000);
        repeat (SEQ_CHK ? 3 : 1) exp_rd.push_back(48'h6008);
        exp_rd.push_back(48'h6010);
        exp_cmd.push_back(ent(1'b1, 1'b0, 0, 48'h60));
        exp_cmd.push_back(SEQ_CHK ? ent(1'b1, 1'b0, 1, 48'h61) : ent(1'b1, 1'b0, 5, 48'h61));
        do_start(48'h6000, 16'd9);
        wait_idle("t6");
        chk("t6_rd_left", 64'(exp_rd.size()), 64'd0);
        chk("t6_cmd_left", 64'(exp_cmd.size()), 64'd0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
